axi4_slave_mem_responder: RTL and testbench

- AXI4 slave (responder) end of the AXI4 interface: accepts write and read bursts from the master BFM and answers them from an internal word-addressed register memory.
- Write path (AW/W/B) and read path (AR/R) are independent, with one outstanding transaction per direction.
- Sits on the slave side of the interface in the HDL top; serves as the DUT-side memory model for FIFO/BFM regression.

---
 rtl/axi4_globals_pkg.sv | 5 +
 rtl/axi4_slave_mem_responder_pkg.sv | 17 +
 rtl/axi4_slave_addr_gen.sv | 45 ++++
 rtl/axi4_slave_mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_axi4_slave_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_globals_pkg.sv
// Interface-wide widths shared by every AXI4 agent in the testbench top.
package axi4_globals_pkg;
    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;
endpackage

// File: rtl/axi4_slave_mem_responder_pkg.sv
// Types and helpers for the AXI4 slave memory responder.
package axi4_slave_mem_responder_pkg;
    import axi4_globals_pkg::*;

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int LOG2_BYTES = $clog2(BYTES);

    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_e;
    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    function automatic logic [ADDRESS_WIDTH-1:0] align_addr(input logic [ADDRESS_WIDTH-1:0] addr,
                                                            input logic [2:0] size);
        return addr & ~((ADDRESS_WIDTH'(1) << size) - ADDRESS_WIDTH'(1));
    endfunction
endpackage

// File: rtl/axi4_slave_addr_gen.sv
// Purpose: next beat address, burst legality and memory range/index for one AXI channel.
// Latency: purely combinational.
// Backpressure: none; caller advances the address only on a data handshake.
module axi4_slave_addr_gen
    import axi4_globals_pkg::*;
    import axi4_slave_mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic [ADDRESS_WIDTH-1:0]     addr,
    input  logic [3:0]                   len,
    input  logic [2:0]                   size,
    input  logic [1:0]                   burst,
    output logic [ADDRESS_WIDTH-1:0]     next_addr,
    output logic                         legal,
    output logic                         in_range,
    output logic [$clog2(MEM_DEPTH)-1:0] index
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] SPAN = ADDRESS_WIDTH'(MEM_DEPTH * BYTES);

    logic [ADDRESS_WIDTH-1:0] incr_addr;
    logic [ADDRESS_WIDTH-1:0] wrap_mask;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic                     wrap_len_ok;

    always_comb begin
        incr_addr   = addr + (ADDRESS_WIDTH'(1) << size);
        // A wrap block is (len+1) beats wide; legal lengths make this a power of two.
        wrap_mask   = ((ADDRESS_WIDTH'(len) + ADDRESS_WIDTH'(1)) << size) - ADDRESS_WIDTH'(1);
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        offset      = addr - BASE_ADDR;

        case (burst)
            INCR:    next_addr = incr_addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = addr;
        endcase

        legal    = (burst != RSVD) && (size <= 3'(LOG2_BYTES)) && ((burst != WRAP) || wrap_len_ok);
        in_range = (addr >= BASE_ADDR) && (offset < SPAN);
        index    = IDX_W'(offset >> LOG2_BYTES);
    end
endmodule

// File: rtl/axi4_slave_mem_responder.sv
// Purpose: AXI4 slave answering write/read bursts from an internal word memory.
// Latency: first R beat the cycle after AR accept; B the cycle after the last W beat.
// Backpressure: one burst per direction; AW/AR held off until B/last R handshakes.
module axi4_slave_mem_responder
    import axi4_globals_pkg::*;
    import axi4_slave_mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [3:0]                 awid,
    input  logic [ADDRESS_WIDTH-1:0]   awaddr,
    input  logic [3:0]                 awlen,
    input  logic [2:0]                 awsize,
    input  logic [1:0]                 awburst,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic                       wlast,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [3:0]                 bid,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [3:0]                 arid,
    input  logic [ADDRESS_WIDTH-1:0]   araddr,
    input  logic [3:0]                 arlen,
    input  logic [2:0]                 arsize,
    input  logic [1:0]                 arburst,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [3:0]                 rid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [1:0]                 rresp,
    output logic                       rlast,
    output logic                       rvalid,
    input  logic                       rready
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wr_state_e                wr_state, wr_next;
    logic [ADDRESS_WIDTH-1:0] wr_addr, wr_next_addr;
    logic [3:0]               wr_len, wr_cnt;
    logic [2:0]               wr_size;
    logic [1:0]               wr_burst;
    logic                     wr_err, wr_legal, wr_in_range, wr_last_beat, wr_beat_err;
    logic [IDX_W-1:0]         wr_index;

    rd_state_e                rd_state, rd_next;
    logic [ADDRESS_WIDTH-1:0] rd_addr, rg_addr, rg_next_addr;
    logic [3:0]               rd_len, rd_cnt, rg_len;
    logic [2:0]               rd_size, rg_size;
    logic [1:0]               rd_burst, rg_burst;
    logic                     rg_legal, rg_in_range, rg_ok;
    logic [IDX_W-1:0]         rg_index;

    logic aw_hs, w_hs, ar_hs, r_hs;

    assign aw_hs        = awvalid & awready;
    assign w_hs         = wvalid & wready;
    assign ar_hs        = arvalid & arready;
    assign r_hs         = rvalid & rready;
    assign wr_last_beat = (wr_cnt == wr_len);
    assign wr_beat_err  = !wr_in_range || (wlast != wr_last_beat);

    axi4_slave_addr_gen #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_wr_addr_gen (
        .addr(wr_addr), .len(wr_len), .size(wr_size), .burst(wr_burst),
        .next_addr(wr_next_addr), .legal(wr_legal), .in_range(wr_in_range), .index(wr_index)
    );

    // rd_addr always holds the address of the beat to fetch next; in idle the
    // incoming AR request is evaluated directly so beat 0 is fetched on accept.
    assign rg_addr  = (rd_state == R_IDLE) ? align_addr(araddr, arsize) : rd_addr;
    assign rg_len   = (rd_state == R_IDLE) ? arlen   : rd_len;
    assign rg_size  = (rd_state == R_IDLE) ? arsize  : rd_size;
    assign rg_burst = (rd_state == R_IDLE) ? arburst : rd_burst;
    assign rg_ok    = rg_legal && rg_in_range;

    axi4_slave_addr_gen #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_rd_addr_gen (
        .addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
        .next_addr(rg_next_addr), .legal(rg_legal), .in_range(rg_in_range), .index(rg_index)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                awready = !areset;
                if (awvalid && !areset) wr_next = W_DATA;
            end
            W_DATA: begin
                wready = !areset;
                if (wvalid && !areset && wr_last_beat) wr_next = W_RESP;
            end
            W_RESP: begin
                bvalid = !areset;
                if (bready && !areset) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready = !areset;
                if (arvalid && !areset) rd_next = R_DATA;
            end
            R_DATA: begin
                rvalid = !areset;
                if (rready && !areset && rlast) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            bid      <= '0;
            bresp    <= '0;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_cnt   <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_err   <= 1'b0;
        end else if (aw_hs) begin
            bid      <= awid;
            wr_addr  <= align_addr(awaddr, awsize);
            wr_len   <= awlen;
            wr_size  <= awsize;
            wr_burst <= awburst;
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
        end else if (w_hs) begin
            wr_addr <= wr_next_addr;
            wr_cnt  <= wr_cnt + 4'd1;
            wr_err  <= wr_err | wr_beat_err;
            if (wr_last_beat)
                bresp <= (!wr_legal || wr_err || wr_beat_err) ? SLVERR : OKAY;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && wr_legal && wr_in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) mem[wr_index][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rid      <= '0;
            rdata    <= '0;
            rresp    <= '0;
            rlast    <= 1'b0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
        end else if (ar_hs) begin
            rid      <= arid;
            rd_len   <= arlen;
            rd_size  <= arsize;
            rd_burst <= arburst;
            rd_cnt   <= '0;
            rd_addr  <= rg_next_addr;
            rdata    <= rg_ok ? mem[rg_index] : '0;
            rresp    <= rg_ok ? OKAY : SLVERR;
            rlast    <= (arlen == 4'd0);
        end else if (r_hs && !rlast) begin
            rd_cnt  <= rd_cnt + 4'd1;
            rd_addr <= rg_next_addr;
            rdata   <= rg_ok ? mem[rg_index] : '0;
            rresp   <= rg_ok ? OKAY : SLVERR;
            rlast   <= ((rd_cnt + 4'd1) == rd_len);
        end
    end
endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// Scoreboard bench: expected B/R responses are queued when a burst is issued
// and popped as the responder produces them.
module tb_axi4_slave_mem_responder;
    import axi4_globals_pkg::*;
    import axi4_slave_mem_responder_pkg::*;

    localparam int TMO = 50;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awid, arid, bid, rid, awlen, arlen, wstrb;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;

    bexp_t b_q[$];
    rexp_t r_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    axi4_slave_mem_responder dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
        rexp_t e;
        e.data = d; e.resp = resp; e.last = last; e.id = id;
        r_q.push_back(e);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (awready !== 1'b1 && t < TMO) begin @(posedge aclk); #1; t++; end
        if (t >= TMO) begin n_cmp++; n_err++; $display("FAIL aw_timeout: awready never 1"); end
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
        int t = 0;
        wdata = d; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (wready !== 1'b1 && t < TMO) begin @(posedge aclk); #1; t++; end
        if (t >= TMO) begin n_cmp++; n_err++; $display("FAIL w_timeout: wready never 1"); end
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic recv_b(input int bhold);
        int t = 0;
        bexp_t e;
        if (b_q.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL b_queue: no expected B response");
            return;
        end
        e = b_q.pop_front();
        bready = 1'b0;
        while (bvalid !== 1'b1 && t < TMO) begin @(posedge aclk); #1; t++; end
        if (t >= TMO) begin n_cmp++; n_err++; $display("FAIL b_timeout: bvalid never 1"); end
        for (int k = 0; k < bhold; k++) begin
            n_cmp++;
            if ({bvalid, awready, bresp} !== {1'b1, 1'b0, e.resp}) begin
                n_err++;
                $display("FAIL b_hold cyc %0d: bvalid=%b awready=%b bresp=%b, need 1 0 %b",
                         k, bvalid, awready, bresp, e.resp);
            end
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        n_cmp++;
        if ({bvalid, bid, bresp} !== {1'b1, e.id, e.resp}) begin
            n_err++;
            $display("FAIL b_resp: bvalid=%b bid=%h bresp=%b, need 1 %h %b", bvalid, bid, bresp, e.id, e.resp);
        end
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    // Data of beat i is base+i; wlast also raised on beat 'early' when early >= 0.
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                               input logic [3:0] strb, input int early, input logic [1:0] exp_resp,
                               input int bhold);
        bexp_t e;
        e.id = id; e.resp = exp_resp;
        b_q.push_back(e);
        send_aw(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++)
            send_w(base + 32'(i), strb, (i == int'(len)) || (i == early));
        recv_b(bhold);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int hold_beat, input int hold_cycles);
        int t;
        rexp_t e;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (arready !== 1'b1 && t < TMO) begin @(posedge aclk); #1; t++; end
        if (t >= TMO) begin n_cmp++; n_err++; $display("FAIL ar_timeout: arready never 1"); end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (r_q.size() == 0) begin
                n_cmp++; n_err++; $display("FAIL r_queue: no expected beat %0d", i);
                return;
            end
            rready = (i != hold_beat);
            t = 0;
            while (rvalid !== 1'b1 && t < TMO) begin @(posedge aclk); #1; t++; end
            if (t >= TMO) begin n_cmp++; n_err++; $display("FAIL r_timeout: beat %0d", i); end
            if (i == hold_beat) begin
                for (int k = 0; k < hold_cycles; k++) begin
                    n_cmp++;
                    if ({rvalid, rdata, rresp, rlast} !== {1'b1, r_q[0].data, r_q[0].resp, r_q[0].last}) begin
                        n_err++;
                        $display("FAIL r_hold cyc %0d: rvalid=%b rdata=%h rlast=%b, need 1 %h %b",
                                 k, rvalid, rdata, rlast, r_q[0].data, r_q[0].last);
                    end
                    @(posedge aclk); #1;
                end
                rready = 1'b1;
            end
            e = r_q.pop_front();
            n_cmp++;
            if ({rdata, rresp, rlast, rid} !== {e.data, e.resp, e.last, e.id}) begin
                n_err++;
                $display("FAIL r_beat %0d: rdata=%h rresp=%b rlast=%b rid=%h, need %h %b %b %h",
                         i, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
            end
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        n_cmp++;
        if ({arready, rvalid} !== 2'b10) begin
            n_err++;
            $display("FAIL r_done: arready=%b rvalid=%b, need 1 0", arready, rvalid);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        n_cmp++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_handshake: got %b need 00000", {awready, wready, bvalid, arready, rvalid});
        end
        n_cmp++;
        if ({bid, rid, bresp, rresp, rlast, rdata} !== 45'b0) begin
            n_err++;
            $display("FAIL reset_outputs: bid=%h rid=%h bresp=%b rresp=%b rlast=%b rdata=%h, need all 0",
                     bid, rid, bresp, rresp, rlast, rdata);
        end
        areset = 1'b0;
        wvalid = 1'b1;
        #1;
        n_cmp++;
        if ({awready, arready, wready} !== 3'b110) begin
            n_err++;
            $display("FAIL post_reset_ready: aw/ar/w ready=%b need 110", {awready, arready, wready});
        end
        @(posedge aclk); #1;
        n_cmp++;
        if (wready !== 1'b0) begin
            n_err++; $display("FAIL w_in_idle: wready=%b need 0", wready);
        end
        wvalid = 1'b0;
    endtask

    task automatic test_incr();
        write_burst(4'h3, 32'h10, 4'd3, 3'd2, INCR, 32'hA0, 4'hF, -1, OKAY, 0);
        for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), OKAY, i == 3, 4'h9);
        read_burst(4'h9, 32'h10, 4'd3, 3'd2, INCR, -1, 0);
    endtask

    task automatic test_wrap();
        write_burst(4'h1, 32'h20, 4'd3, 3'd2, INCR, 32'hB0, 4'hF, -1, OKAY, 0);
        push_r(32'hB2, OKAY, 1'b0, 4'h2);
        push_r(32'hB3, OKAY, 1'b0, 4'h2);
        push_r(32'hB0, OKAY, 1'b0, 4'h2);
        push_r(32'hB1, OKAY, 1'b1, 4'h2);
        read_burst(4'h2, 32'h28, 4'd3, 3'd2, WRAP, -1, 0);
        for (int i = 0; i < 3; i++) push_r(32'h0, SLVERR, i == 2, 4'h4);
        read_burst(4'h4, 32'h28, 4'd2, 3'd2, WRAP, -1, 0);
    endtask

    task automatic test_strobe();
        write_burst(4'h5, 32'h40, 4'd0, 3'd2, INCR, 32'hFFFF_FFFF, 4'hF, -1, OKAY, 0);
        write_burst(4'h5, 32'h40, 4'd0, 3'd2, INCR, 32'h1234_5678, 4'b0101, -1, OKAY, 0);
        push_r(32'hFF34_FF78, OKAY, 1'b1, 4'h6);
        read_burst(4'h6, 32'h40, 4'd0, 3'd2, INCR, -1, 0);
    endtask

    task automatic test_fixed();
        write_burst(4'h7, 32'h90, 4'd2, 3'd2, FIXED, 32'hD0, 4'hF, -1, OKAY, 0);
        push_r(32'hD2, OKAY, 1'b0, 4'h7);
        push_r(32'h0, OKAY, 1'b1, 4'h7);
        write_burst(4'h7, 32'h94, 4'd0, 3'd2, INCR, 32'h0, 4'hF, -1, OKAY, 0);
        read_burst(4'h7, 32'h90, 4'd1, 3'd2, INCR, -1, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), OKAY, i == 3, 4'hC);
        read_burst(4'hC, 32'h10, 4'd3, 3'd2, INCR, 1, 5);
        for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), OKAY, i == 3, 4'hD);
        read_burst(4'hD, 32'h10, 4'd3, 3'd2, INCR, 3, 5);
        write_burst(4'hE, 32'h30, 4'd0, 3'd2, INCR, 32'h77, 4'hF, -1, OKAY, 3);
    endtask

    task automatic test_errors();
        write_burst(4'h8, 32'h3FC, 4'd3, 3'd2, INCR, 32'hF0, 4'hF, -1, SLVERR, 0);
        push_r(32'hF0, OKAY, 1'b0, 4'h8);
        push_r(32'h0, SLVERR, 1'b1, 4'h8);
        read_burst(4'h8, 32'h3FC, 4'd1, 3'd2, INCR, -1, 0);
        write_burst(4'hA, 32'hA0, 4'd3, 3'd2, INCR, 32'hE0, 4'hF, 1, SLVERR, 0);
        write_burst(4'hB, 32'h50, 4'd0, 3'd2, INCR, 32'h55AA_55AA, 4'hF, -1, OKAY, 0);
        write_burst(4'hB, 32'h50, 4'd0, 3'd2, RSVD, 32'hDEAD_BEEF, 4'hF, -1, SLVERR, 0);
        push_r(32'h55AA_55AA, OKAY, 1'b1, 4'hB);
        read_burst(4'hB, 32'h50, 4'd0, 3'd2, INCR, -1, 0);
        push_r(32'h0, SLVERR, 1'b1, 4'hB);
        read_burst(4'hB, 32'h50, 4'd0, 3'd3, INCR, -1, 0);
    endtask

    task automatic test_reset_mid_burst();
        send_aw(4'h5, 32'h60, 4'd3, 3'd2, INCR);
        send_w(32'hC0, 4'hF, 1'b0);
        send_w(32'hC1, 4'hF, 1'b0);
        areset = 1'b1;
        #1;
        n_cmp++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL mid_reset_handshake: got %b need 00000", {awready, wready, bvalid, arready, rvalid});
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        #1;
        n_cmp++;
        if ({awready, wready, bvalid} !== 3'b100) begin
            n_err++;
            $display("FAIL mid_reset_idle: aw/w ready,bvalid=%b need 100", {awready, wready, bvalid});
        end
        write_burst(4'h6, 32'h80, 4'd1, 3'd2, INCR, 32'h11, 4'hF, -1, OKAY, 0);
        push_r(32'hC0, OKAY, 1'b0, 4'h3);
        push_r(32'hC1, OKAY, 1'b1, 4'h3);
        read_burst(4'h3, 32'h60, 4'd1, 3'd2, INCR, -1, 0);
        push_r(32'h11, OKAY, 1'b0, 4'h3);
        push_r(32'h12, OKAY, 1'b1, 4'h3);
        read_burst(4'h3, 32'h80, 4'd1, 3'd2, INCR, -1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_incr();
        test_wrap();
        test_strobe();
        test_fixed();
        test_backpressure();
        test_errors();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
